sa_feed_ctrl: RTL and testbench

SA_FEED_CTRL -- requirements
Module: sa_feed_ctrl

---
 rtl/sa_feed_ctrl.sv | 108 ++++++++++
 tb/tb_sa_feed_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sa_feed_ctrl.sv
// Systolic-array feed controller: sequences clear, skewed operand reads, drain and done for one job.
// Optional build macro SA_FEED_CTRL_PERF_EN adds the cycles_o busy-cycle counter.
module sa_feed_ctrl #(
   parameter int unsigned NUM_ROWS   = 16,
   parameter int unsigned NUM_COLS   = 16,
   parameter int unsigned K_WIDTH    = 16,
   parameter int unsigned PE_LATENCY = 2
) (
   input  logic                clk_i,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic [K_WIDTH-1:0]  k_len_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                acc_clr_o,
   output logic [NUM_ROWS-1:0] in_rd_en_o,
   output logic [K_WIDTH-1:0]  in_rd_addr_o [NUM_ROWS],
   output logic [NUM_ROWS-1:0] in_valid_o,
   output logic [NUM_COLS-1:0] wt_rd_en_o,
   output logic [K_WIDTH-1:0]  wt_rd_addr_o [NUM_COLS],
   output logic [NUM_COLS-1:0] wt_valid_o
`ifdef SA_FEED_CTRL_PERF_EN
   ,output logic [31:0]        cycles_o
`endif
);

   localparam int unsigned TW         = K_WIDTH + 1;
   localparam int unsigned DW         = (PE_LATENCY > 1) ? $clog2(PE_LATENCY) : 1;
   localparam int unsigned DRAIN_LAST = (PE_LATENCY > 0) ? PE_LATENCY - 1 : 0;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      DRAIN,
      DONE
   } state_t;

   state_t          state, state_nx;
   logic [TW-1:0]   t_q;
   logic [TW-1:0]   k_q;
   logic [TW-1:0]   feed_last;
   logic [DW-1:0]   drain_q;

   // Last FEED step is K+ROWS+COLS-3; K>=1 whenever FEED is entered, so no underflow.
   assign feed_last = k_q + TW'(NUM_ROWS + NUM_COLS) - TW'(3);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start_i) state_nx = (k_len_i == '0) ? DONE : CLEAR;
         CLEAR: state_nx = FEED;
         FEED:  if (t_q == feed_last) state_nx = (PE_LATENCY == 0) ? DONE : DRAIN;
         DRAIN: if (drain_q == DW'(DRAIN_LAST)) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         state      <= IDLE;
         t_q        <= '0;
         k_q        <= '0;
         drain_q    <= '0;
         in_valid_o <= '0;
         wt_valid_o <= '0;
      end else begin
         state      <= state_nx;
         in_valid_o <= in_rd_en_o;
         wt_valid_o <= wt_rd_en_o;
         if (state == IDLE && start_i) k_q <= {1'b0, k_len_i};
         t_q     <= (state == FEED)  ? t_q + TW'(1)     : '0;
         drain_q <= (state == DRAIN) ? drain_q + DW'(1) : '0;
      end
   end

`ifdef SA_FEED_CTRL_PERF_EN
   always_ff @(posedge clk_i) begin
      if (!rst_n)                      cycles_o <= '0;
      else if (state == IDLE && start_i) cycles_o <= '0;
      else if (state != IDLE)          cycles_o <= cycles_o + 32'd1;
   end
`endif

   always_comb begin
      busy_o    = (state != IDLE);
      done_o    = (state == DONE);
      acc_clr_o = (state == CLEAR);
      in_rd_en_o = '0;
      wt_rd_en_o = '0;
      for (int unsigned r = 0; r < NUM_ROWS; r++) begin
         in_rd_addr_o[r] = '0;
         if (state == FEED && t_q >= TW'(r) && t_q < TW'(r) + k_q) begin
            in_rd_en_o[r]   = 1'b1;
            in_rd_addr_o[r] = K_WIDTH'(t_q - TW'(r));
         end
      end
      for (int unsigned c = 0; c < NUM_COLS; c++) begin
         wt_rd_addr_o[c] = '0;
         if (state == FEED && t_q >= TW'(c) && t_q < TW'(c) + k_q) begin
            wt_rd_en_o[c]   = 1'b1;
            wt_rd_addr_o[c] = K_WIDTH'(t_q - TW'(c));
         end
      end
   end

endmodule

// File: tb/tb_sa_feed_ctrl.sv
// Randomized bench for sa_feed_ctrl against a job-schedule reference model.
module tb_sa_feed_ctrl;
   localparam int NR = 4;
   localparam int NC = 4;
   localparam int KW = 8;
   localparam int PL = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_i;
   logic [KW-1:0] k_len_i;
   logic          busy_o, done_o, acc_clr_o;
   logic [NR-1:0] in_rd_en_o, in_valid_o;
   logic [KW-1:0] in_rd_addr_o [NR];
   logic [NC-1:0] wt_rd_en_o, wt_valid_o;
   logic [KW-1:0] wt_rd_addr_o [NC];
`ifdef SA_FEED_CTRL_PERF_EN
   logic [31:0]   cycles_o;
`endif

   always #5 clk = ~clk;

   sa_feed_ctrl #(
      .NUM_ROWS(NR), .NUM_COLS(NC), .K_WIDTH(KW), .PE_LATENCY(PL)
   ) dut (
      .clk_i(clk), .rst_n(rst_n), .start_i(start_i), .k_len_i(k_len_i),
      .busy_o(busy_o), .done_o(done_o), .acc_clr_o(acc_clr_o),
      .in_rd_en_o(in_rd_en_o), .in_rd_addr_o(in_rd_addr_o), .in_valid_o(in_valid_o),
      .wt_rd_en_o(wt_rd_en_o), .wt_rd_addr_o(wt_rd_addr_o), .wt_valid_o(wt_valid_o)
`ifdef SA_FEED_CTRL_PERF_EN
      ,.cycles_o(cycles_o)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference job: accepted start in cycle js with length jk
   bit            job_valid = 1'b0;
   int            js = 0;
   int            jk = 0;
   logic [NR-1:0] in_prev = '0;
   logic [NC-1:0] wt_prev = '0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int job_end();
      return (jk == 0) ? js + 1 : js + 2 + (jk + NR + NC - 2) + PL;
   endfunction

   function automatic bit model_idle(input int m);
      return !job_valid || m > job_end();
   endfunction

   function automatic bit exp_en(input int m, input int lane);
      int t;
      t = m - (js + 2);
      return job_valid && jk > 0 && t >= lane && t < lane + jk;
   endfunction

   function automatic int exp_addr(input int m, input int lane);
      return exp_en(m, lane) ? m - (js + 2) - lane : 0;
   endfunction

   function automatic int exp_cycles(input int m);
      int last;
      if (!job_valid) return 0;
      last = (m - 1 < job_end()) ? m - 1 : job_end();
      return (last - js > 0) ? last - js : 0;
   endfunction

   task automatic check_cycle();
      check_eq("busy", 64'(busy_o), 64'(job_valid && cyc >= js + 1 && cyc <= job_end()));
      check_eq("done", 64'(done_o), 64'(job_valid && cyc == job_end()));
      check_eq("acc_clr", 64'(acc_clr_o), 64'(job_valid && jk > 0 && cyc == js + 1));
      for (int r = 0; r < NR; r++) begin
         check_eq($sformatf("in_rd_en[%0d]", r), 64'(in_rd_en_o[r]), 64'(exp_en(cyc, r)));
         check_eq($sformatf("in_rd_addr[%0d]", r), 64'(in_rd_addr_o[r]), 64'(exp_addr(cyc, r)));
         check_eq($sformatf("in_valid[%0d]", r), 64'(in_valid_o[r]), 64'(in_prev[r]));
      end
      for (int c = 0; c < NC; c++) begin
         check_eq($sformatf("wt_rd_en[%0d]", c), 64'(wt_rd_en_o[c]), 64'(exp_en(cyc, c)));
         check_eq($sformatf("wt_rd_addr[%0d]", c), 64'(wt_rd_addr_o[c]), 64'(exp_addr(cyc, c)));
         check_eq($sformatf("wt_valid[%0d]", c), 64'(wt_valid_o[c]), 64'(wt_prev[c]));
      end
`ifdef SA_FEED_CTRL_PERF_EN
      check_eq("cycles", 64'(cycles_o), 64'(exp_cycles(cyc)));
`endif
   endtask

   // Drive cycle cyc's inputs, advance one edge, update the model, check the new cycle.
   task automatic step(input bit rst, input bit st, input int k);
      rst_n   = rst;
      start_i = st;
      k_len_i = KW'(k);
      @(posedge clk);
      if (!rst) begin
         job_valid = 1'b0;
         in_prev   = '0;
         wt_prev   = '0;
      end else begin
         for (int r = 0; r < NR; r++) in_prev[r] = exp_en(cyc, r);
         for (int c = 0; c < NC; c++) wt_prev[c] = exp_en(cyc, c);
         if (st && model_idle(cyc)) begin
            job_valid = 1'b1;
            js        = cyc;
            jk        = k;
         end
      end
      cyc++;
      #1;
      check_cycle();
   endtask

   initial begin
      int base;
      rst_n   = 1'b0;
      start_i = 1'b0;
      k_len_i = '0;
      step(0, 0, 0);
      step(0, 0, 0);

      // Reference K=3 job: done exactly 13 cycles after the start cycle
      base = cyc;
      step(1, 1, 3);
      repeat (12) step(1, 0, $urandom_range(0, 255));
      check_eq("done_at_13", 64'(done_o), 64'(cyc == base + 13));
      step(1, 0, 7);
`ifdef SA_FEED_CTRL_PERF_EN
      check_eq("cycles_13", 64'(cycles_o), 64'd13);
`endif
      repeat (3) step(1, 0, 0);

      // K=0 job
      step(1, 1, 0);
      repeat (4) step(1, 0, 5);

      // Reset in cycle 6 of a job, restart in cycle 8
      step(1, 1, 3);
      repeat (5) step(1, 0, 3);
      step(0, 1, 3);
      step(1, 0, 0);
      step(1, 1, 3);
      repeat (15) step(1, 0, 2);

      // start held high for 21 cycles
      repeat (21) step(1, 1, 3);
      repeat (20) step(1, 0, 0);

      // Maximum K: step counter must pass 2^K_WIDTH without wrapping
      step(1, 1, 255);
      repeat (275) step(1, 0, 1);

      repeat (3000) begin
         bit r, s;
         int k;
         r = ($urandom_range(0, 59) != 0);
         s = ($urandom_range(0, 2) == 0);
         k = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
         step(r, s, k);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
